rgb_pwm_sequencer: RTL and testbench
====================================

RGB_PWM_SEQUENCER -- requirements
Module: rgb_pwm_sequencer

Interface
REQ-001 Parameter DEBOUNCE_LOG2, default 16: debounce counter width; a button level must be stable for 2^DEBOUNCE_LOG2 clocks before it is accepted.
REQ-002 Parameter STEP_LOG2, default 14: step-timer width; one step_tick every 2^STEP_LOG2 clocks.
REQ-003 clk  input  1: single clock; all state on posedge clk.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 btn_n  input  1: raw active-low push button, asynchronous to clk.
REQ-006 duty_r, duty_g, duty_b  input  8 each: requested per-channel duty, 0..255.
REQ-007 pwm_r, pwm_g, pwm_b  output  1 each: registered PWM drive for the RGB LED driver PWM inputs.
REQ-008 mode  output  2: current mode (0 OFF, 1 SOLID, 2 BLINK, 3 BREATHE).
REQ-009 press  output  1: single-cycle pulse on each accepted button press.
REQ-010 level  output  8: current breathe level.

Function
REQ-011 btn_n SHALL pass through a 2-flop synchronizer; both flops reset to 1.
REQ-012 Debounce: counter clears whenever synced == stable; otherwise it increments, and on the cycle it is all-ones, stable <= synced and the counter clears.
REQ-013 press SHALL pulse high for exactly one cycle, in the cycle after stable transitions 1->0; a 0->1 transition produces no pulse.
REQ-014 Mode FSM: each press advances OFF->SOLID->BLINK->BREATHE->OFF (3 wraps to 0); no other transitions.
REQ-015 PWM counter: 8-bit, free-running, increments every cycle, wraps 255->0.
REQ-016 Step timer: STEP_LOG2-bit free-running counter; step_tick is asserted on the cycle it is all-ones.
REQ-017 Breathe: level and dir (up = 1) update on step_tick; going up, level increments until 255, then dir flips down; going down, level decrements until 0, then dir flips up. The flip occurs on the tick at the endpoint, with level held at that endpoint for that tick.
REQ-018 On press: level <= 0, dir <= up, step timer <= 0. Press takes priority over a coincident step_tick.
REQ-019 Effective duty eff_x per channel:
  - OFF: 0.
  - SOLID: duty_x.
  - BLINK: duty_x when dir = up, else 0.
  - BREATHE: (duty_x * level) >> 8, using a 16-bit product and taking the upper 8 bits.
REQ-020 Shadow duty: shadow_x <= eff_x only on the cycle where the PWM counter is 255; otherwise shadow_x holds. Duty and mode changes therefore take effect only at a period boundary, with no mid-period glitch.
REQ-021 pwm_x is registered: pwm_x(t+1) = (pwm_cnt(t) < shadow_x(t)).
  - shadow 0: never high.
  - shadow 255: high 255 of every 256 cycles.
  - Duty is exactly shadow/256.
REQ-022 Entering OFF: the current period completes with the old shadow; all pwm outputs are 0 from the next period.
REQ-023 All three channels SHALL share the same PWM counter, so channel periods are phase-aligned.

Reset
REQ-024 While rst_n = 0, effective immediately and without a clock:
  - synchronizer flops and stable = 1;
  - all counters, level, shadows, press and pwm_r/g/b = 0;
  - dir = up; mode = OFF.
REQ-025 After rst_n rises, the first PWM period starts with pwm_cnt = 0 and shadows = 0.
REQ-026 Reset asserted mid-operation SHALL abandon any in-progress debounce; no press is generated on release.

Verification (DEBOUNCE_LOG2 = 2, STEP_LOG2 = 2)
REQ-027 Assert rst_n low mid-period in SOLID with pwm_r high -> pwm_r = 0 and mode = 0 before the next clock edge; after release, no PWM activity for the first 256 cycles.
REQ-028 btn_n low for 2 cycles, then high -> no press, mode unchanged; btn_n held low for 8 cycles -> exactly one press pulse, mode 0->1; release -> no pulse.
REQ-029 SOLID with duty_r = 64, duty_g = 0, duty_b = 255 -> per 256-cycle period, pwm_r high 64 cycles, pwm_g 0 cycles, pwm_b 255 cycles, all rising in the same cycle.
REQ-030 SOLID with duty_r changed 64->128 at pwm_cnt = 100 -> current period shows 64 high cycles, next period 128.
REQ-031 Four accepted presses -> mode sequence 1, 2, 3, 0; after the next period boundary, all pwm outputs stay 0.
REQ-032 BREATHE with duty_b = 255 -> level ramps 0..255 at one step per 4 clocks, holds one tick, ramps down, then repeats; each period's pwm_b high count = (255*level_at_load) >> 8; a press mid-ramp restarts level at 0 with dir up.

Source files
------------

// File: rtl/rgb_pwm_sequencer.sv
// RGB LED sequencer: a debounced button steps OFF/SOLID/BLINK/BREATHE and drives
// three phase-aligned 8-bit PWM channels whose duty only changes at period boundaries.
module rgb_pwm_sequencer #(
  parameter int unsigned DEBOUNCE_LOG2 = 16,
  parameter int unsigned STEP_LOG2     = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  input  logic [7:0] duty_r,
  input  logic [7:0] duty_g,
  input  logic [7:0] duty_b,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic [1:0] mode,
  output logic       press,
  output logic [7:0] level
);

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 2 * DW;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  mode_e                   state;
  mode_e                   state_next;
  logic [1:0]              sync;
  logic                    stable;
  logic                    stable_d;
  logic [DEBOUNCE_LOG2-1:0] deb_cnt;
  logic [DW-1:0]           pwm_cnt;
  logic [STEP_LOG2-1:0]    step_cnt;
  logic                    step_tick;
  logic                    dir;
  logic [DW-1:0]           eff_r;
  logic [DW-1:0]           eff_g;
  logic [DW-1:0]           eff_b;
  logic [DW-1:0]           shadow_r;
  logic [DW-1:0]           shadow_g;
  logic [DW-1:0]           shadow_b;

  assign mode      = 2'(state);
  assign step_tick = &step_cnt;

  // Button synchronizer, debounce, and falling-edge press pulse one cycle after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= 2'b11;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      deb_cnt  <= '0;
      press    <= 1'b0;
    end else begin
      sync     <= {sync[0], btn_n};
      stable_d <= stable;
      press    <= stable_d & ~stable;
      if (sync[1] == stable) begin
        deb_cnt <= '0;
      end else if (&deb_cnt) begin
        stable  <= sync[1];
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEBOUNCE_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MODE_OFF;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (press) begin
      case (state)
        MODE_OFF:     state_next = MODE_SOLID;
        MODE_SOLID:   state_next = MODE_BLINK;
        MODE_BLINK:   state_next = MODE_BREATHE;
        MODE_BREATHE: state_next = MODE_OFF;
        default:      state_next = MODE_OFF;
      endcase
    end
  end

  // Triangle breathe level; a press restarts the ramp and realigns the step timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      level    <= '0;
      dir      <= 1'b1;
    end else if (press) begin
      step_cnt <= '0;
      level    <= '0;
      dir      <= 1'b1;
    end else begin
      step_cnt <= step_cnt + STEP_LOG2'(1);
      if (step_tick) begin
        if (dir) begin
          if (level == {DW{1'b1}}) dir <= 1'b0;
          else                     level <= level + DW'(1);
        end else begin
          if (level == '0) dir <= 1'b1;
          else             level <= level - DW'(1);
        end
      end
    end
  end

  function automatic logic [DW-1:0] eff_duty(input mode_e m, input logic [DW-1:0] d,
                                             input logic [DW-1:0] lvl, input logic up);
    logic [PW-1:0] prod;
    logic [DW-1:0] res;
    prod = PW'(d) * PW'(lvl);
    res  = '0;
    case (m)
      MODE_OFF:     res = '0;
      MODE_SOLID:   res = d;
      MODE_BLINK:   res = up ? d : '0;
      MODE_BREATHE: res = prod[PW-1:DW];
      default:      res = '0;
    endcase
    return res;
  endfunction

  always_comb begin
    eff_r = eff_duty(state, duty_r, level, dir);
    eff_g = eff_duty(state, duty_g, level, dir);
    eff_b = eff_duty(state, duty_b, level, dir);
  end

  // Shared PWM counter; shadows reload only on the last count of a period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      shadow_r <= '0;
      shadow_g <= '0;
      shadow_b <= '0;
      pwm_r    <= 1'b0;
      pwm_g    <= 1'b0;
      pwm_b    <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + DW'(1);
      pwm_r   <= pwm_cnt < shadow_r;
      pwm_g   <= pwm_cnt < shadow_g;
      pwm_b   <= pwm_cnt < shadow_b;
      if (pwm_cnt == {DW{1'b1}}) begin
        shadow_r <= eff_r;
        shadow_g <= eff_g;
        shadow_b <= eff_b;
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Self-checking bench for rgb_pwm_sequencer: a behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations and a randomized phase.
module tb_rgb_pwm_sequencer;

  localparam int DB  = 2;
  localparam int SL  = 2;
  localparam int DBN = 1 << DB;
  localparam int SN  = 1 << SL;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       btn_n  = 1'b1;
  logic [7:0] duty_r = 8'd0;
  logic [7:0] duty_g = 8'd0;
  logic [7:0] duty_b = 8'd0;
  logic       pwm_r;
  logic       pwm_g;
  logic       pwm_b;
  logic [1:0] mode;
  logic       press;
  logic [7:0] level;

  int checks = 0;
  int errors = 0;

  rgb_pwm_sequencer #(.DEBOUNCE_LOG2(DB), .STEP_LOG2(SL)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
    .mode(mode), .press(press), .level(level)
  );

  always #5 clk = ~clk;

  // Model state: cycle/tick counts rather than register images
  int m_s1 = 1, m_s2 = 1, m_stable = 1, m_stable_prev = 1, m_run = 0, m_press = 0;
  int m_mode = 0, m_c = 0, m_k = 0, m_pcnt = 0;
  int m_sh[3];
  int m_pwm[3];

  function automatic int tri_level(input int k);
    int m;
    m = k % 512;
    return (m <= 255) ? m : 511 - m;
  endfunction

  function automatic int tri_up(input int k);
    return ((k % 512) <= 255) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_s1 = 1; m_s2 = 1; m_stable = 1; m_stable_prev = 1; m_run = 0; m_press = 0;
    m_mode = 0; m_c = 0; m_k = 0; m_pcnt = 0;
    for (int i = 0; i < 3; i++) begin
      m_sh[i] = 0;
      m_pwm[i] = 0;
    end
  endtask

  task automatic model_step();
    int d[3];
    int lvl, up, eff, n_press;
    d[0] = int'(duty_r); d[1] = int'(duty_g); d[2] = int'(duty_b);
    lvl = tri_level(m_k);
    up  = tri_up(m_k);
    for (int i = 0; i < 3; i++) begin
      case (m_mode)
        0:       eff = 0;
        1:       eff = d[i];
        2:       eff = (up == 1) ? d[i] : 0;
        default: eff = (d[i] * lvl) >> 8;
      endcase
      m_pwm[i] = (m_pcnt < m_sh[i]) ? 1 : 0;
      if (m_pcnt == 255) m_sh[i] = eff;
    end
    m_pcnt = (m_pcnt + 1) % 256;
    if (m_press == 1) begin
      m_c = 0;
      m_k = 0;
      m_mode = (m_mode + 1) % 4;
    end else begin
      if ((m_c % SN) == SN - 1) m_k++;
      m_c++;
    end
    n_press = (m_stable_prev == 1 && m_stable == 0) ? 1 : 0;
    m_stable_prev = m_stable;
    if (m_s2 == m_stable) m_run = 0;
    else if (m_run == DBN - 1) begin
      m_stable = m_s2;
      m_run = 0;
    end else m_run++;
    m_s2 = m_s1;
    m_s1 = int'(btn_n);
    m_press = n_press;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired (t=%0t)", name, $time);
  endtask

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("pwm_r", pwm_r, m_pwm[0]);
        check("pwm_g", pwm_g, m_pwm[1]);
        check("pwm_b", pwm_b, m_pwm[2]);
        check("mode", mode, m_mode);
        check("press", press, m_press);
        check("level", level, tri_level(m_k));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_press(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      cnt += int'(press);
    end
  endtask

  task automatic hold_btn(input int low, input int high);
    btn_n = 1'b0;
    cycles(low);
    btn_n = 1'b1;
    cycles(high);
  endtask

  task automatic wait_press();
    int n;
    n = 0;
    btn_n = 1'b0;
    while (!press && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) timeout("wait_press");
    btn_n = 1'b1;
  endtask

  task automatic wait_pcnt1();
    int n;
    n = 0;
    while (m_pcnt != 1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) timeout("period_start");
  endtask

  // One full PWM period (outputs derived from counts 0..255); optional duty_r change mid-period
  task automatic measure(input int chg_at, output int r, output int g, output int b,
                         output int fr, output int fb);
    wait_pcnt1();
    r = 0; g = 0; b = 0;
    fr = int'(pwm_r);
    fb = int'(pwm_b);
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      if (i == chg_at) duty_r = 8'd128;
      r += int'(pwm_r);
      g += int'(pwm_g);
      b += int'(pwm_b);
    end
  endtask

  initial begin
    int r, g, b, fr, fb, cnt, cnt2, n, act;

    cycles(4);
    check("rst_pwm_r", pwm_r, 0);
    check("rst_pwm_b", pwm_b, 0);
    check("rst_mode", mode, 0);
    check("rst_level", level, 0);
    check("rst_press", press, 0);
    rst_n = 1'b1;
    cycles(3);

    // Two-cycle glitch is rejected; eight-cycle hold gives one press; release gives none
    btn_n = 1'b0;
    count_press(2, cnt);
    btn_n = 1'b1;
    count_press(20, cnt2);
    check("glitch_press", cnt + cnt2, 0);
    check("glitch_mode", mode, 0);
    btn_n = 1'b0;
    count_press(8, cnt);
    check("hold_press", cnt, 1);
    btn_n = 1'b1;
    count_press(16, cnt);
    check("release_press", cnt, 0);
    check("mode_solid", mode, 1);

    // SOLID per-period high counts and aligned rising edges
    duty_r = 8'd64; duty_g = 8'd0; duty_b = 8'd255;
    measure(-1, r, g, b, fr, fb);
    measure(-1, r, g, b, fr, fb);
    check("solid_r_cnt", r, 64);
    check("solid_g_cnt", g, 0);
    check("solid_b_cnt", b, 255);
    check("solid_r_rise", fr, 1);
    check("solid_b_rise", fb, 1);

    // Mid-period duty change only lands at the next period
    measure(99, r, g, b, fr, fb);
    check("chg_cur_r", r, 64);
    measure(-1, r, g, b, fr, fb);
    check("chg_next_r", r, 128);

    // Async reset mid-period with pwm_r high and a debounce in flight
    wait_pcnt1();
    btn_n = 1'b0;
    cycles(4);
    check("pre_rst_pwm_r", pwm_r, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_pwm_r", pwm_r, 0);
    check("async_rst_mode", mode, 0);
    btn_n = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    act = 0;
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      act += int'(pwm_r | pwm_g | pwm_b);
      cnt += int'(press);
    end
    check("post_rst_pwm_idle", act, 0);
    check("post_rst_no_press", cnt, 0);
    check("post_rst_mode", mode, 0);

    // Full mode cycle, then OFF silences every channel after a boundary
    duty_g = 8'd100;
    hold_btn(8, 16);
    check("seq_mode1", mode, 1);
    hold_btn(8, 16);
    check("seq_mode2", mode, 2);
    hold_btn(8, 16);
    check("seq_mode3", mode, 3);
    hold_btn(8, 16);
    check("seq_mode0", mode, 0);
    measure(-1, r, g, b, fr, fb);
    measure(-1, r, g, b, fr, fb);
    check("off_r_cnt", r, 0);
    check("off_g_cnt", g, 0);
    check("off_b_cnt", b, 0);

    // BREATHE timing: 255 ticks of 4 clocks after the restart cycle, 2-tick hold at top
    duty_r = 8'd0; duty_g = 8'd0; duty_b = 8'd255;
    hold_btn(8, 16);
    hold_btn(8, 16);
    wait_press();
    @(negedge clk);
    n = 1;
    while (level != 8'd255 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("breathe_rise_cycles", n, 1021);
    check("breathe_mode", mode, 3);
    n = 0;
    while (level == 8'd255 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("breathe_top_hold", n, 8);
    n = 0;
    while (level != 8'd200 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) timeout("breathe_descend");
    wait_press();
    cycles(4);
    check("restart_level0", level, 0);
    cycles(1);
    check("restart_level1", level, 1);
    check("restart_mode_off", mode, 0);

    // Randomized phase checked by the model every cycle
    for (int it = 0; it < 50; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          duty_r = 8'($urandom_range(0, 255));
          duty_g = 8'($urandom_range(0, 255));
          duty_b = 8'($urandom_range(0, 255));
        end
        1, 2: hold_btn(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)));
        3: cycles(int'($urandom_range(50, 700)));
        default: begin
          if ($urandom_range(0, 3) == 0) begin
            #1 rst_n = 1'b0;
            cycles(2);
            rst_n = 1'b1;
          end else begin
            cycles(20);
          end
        end
      endcase
    end
    cycles(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
